// File: rtl/rr_mux_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin mux arbiter.
// The arbiter takes the slave modport; the requester side takes master.
interface rr_mux_arbiter_if #(
    parameter int N = 32
);
    localparam int SEL_W = $clog2(N);

    logic             ena;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] sel;
    logic             valid;

    modport master (
        output ena,
        output req,
        input  grant,
        input  sel,
        input  valid
    );

    modport slave (
        input  ena,
        input  req,
        output grant,
        output sel,
        output valid
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of a shared N-way mux; each owner keeps
// the mux for at most QUANTUM cycles while others are waiting.
//
//   state | meaning
//   IDLE  | no owner; grant/sel/valid are all zero
//   GRANT | sel_q owns the mux; cnt counts cycles of the current grant
module rr_mux_arbiter #(
    parameter int N       = 32,
    parameter int QUANTUM = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux_arbiter_if.slave  bus
);
    localparam int SEL_W = $clog2(N);
    localparam int CNT_W = $clog2(QUANTUM + 1);

    localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [N-1:0]     grant_q, grant_nx;
    logic [SEL_W-1:0] sel_q, sel_nx;
    logic             valid_q, valid_nx;
    logic [SEL_W-1:0] ptr, ptr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic [2*N-1:0]   req_rot2;
    logic [N-1:0]     req_rot;
    logic [SEL_W-1:0] pick_ofs;
    logic [SEL_W:0]   pick_sum;
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] pick_ptr_nx;
    logic             any_req;
    logic             other_req;
    logic             owner_req;

    // Rotate req so that index ptr lands at bit 0, take the lowest set bit,
    // then map the offset back to a requester number modulo N.
    always_comb begin
        req_rot2 = {bus.req, bus.req} >> ptr;
        req_rot  = req_rot2[N-1:0];
        pick_ofs = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_ofs = SEL_W'(i);
            end
        end
        pick_sum = {1'b0, ptr} + {1'b0, pick_ofs};
        if (pick_sum >= N_EXT) begin
            pick_sum = pick_sum - N_EXT;
        end
        pick        = pick_sum[SEL_W-1:0];
        pick_ptr_nx = (pick == LAST_IDX) ? '0 : pick + SEL_W'(1);
    end

    assign any_req   = |bus.req;
    assign other_req = |(bus.req & ~grant_q);
    assign owner_req = bus.req[sel_q];

    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        sel_nx   = sel_q;
        valid_nx = valid_q;
        ptr_nx   = ptr;
        cnt_nx   = cnt;

        case (state)
            IDLE: begin
                if (bus.ena && any_req) begin
                    state_nx = GRANT;
                    grant_nx = N'(1) << pick;
                    sel_nx   = pick;
                    valid_nx = 1'b1;
                    ptr_nx   = pick_ptr_nx;
                    cnt_nx   = '0;
                end else begin
                    grant_nx = '0;
                    sel_nx   = '0;
                    valid_nx = 1'b0;
                    cnt_nx   = '0;
                end
            end

            GRANT: begin
                if (!owner_req || (cnt == CNT_LAST && other_req)) begin
                    // Release or quantum end with waiters: hand over without a
                    // bubble if allowed, otherwise drop back to idle.
                    if (bus.ena && other_req) begin
                        grant_nx = N'(1) << pick;
                        sel_nx   = pick;
                        valid_nx = 1'b1;
                        ptr_nx   = pick_ptr_nx;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                        grant_nx = '0;
                        sel_nx   = '0;
                        valid_nx = 1'b0;
                        cnt_nx   = '0;
                    end
                end else if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                sel_nx   = '0;
                valid_nx = 1'b0;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            grant_q <= grant_nx;
            sel_q   <= sel_nx;
            valid_q <= valid_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=8, QUANTUM=3) with a shared 8-way mux on
// sel; expected grants are hand-derived from the round-robin pointer history.
module tb_rr_mux_arbiter;
    localparam int N = 8;
    localparam int Q = 3;

    typedef struct {
        logic       ena;
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] mux_in [N];
    logic [7:0] mux_out;
    vec_t       vecs [$];
    int         n_pass;
    int         n_total;

    rr_mux_arbiter_if #(.N(N)) bus ();

    rr_mux_arbiter #(.N(N), .QUANTUM(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign mux_out = mux_in[bus.sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic shuffle_in();
        for (int i = 0; i < N; i++) mux_in[i] = 8'($urandom);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] eg, input logic [2:0] es,
                       input logic ev);
        n_total++;
        if (bus.grant === eg && bus.sel === es && bus.valid === ev &&
            (!ev || mux_out === mux_in[es])) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got grant=%h sel=%0d valid=%b out=%h, want grant=%h sel=%0d valid=%b out=%h",
                     name, bus.grant, bus.sel, bus.valid, mux_out, eg, es, ev, mux_in[es]);
        end
    endtask

    task automatic add(input logic e, input logic [7:0] r, input logic [7:0] g,
                       input logic [2:0] s, input logic v);
        vec_t t;
        t.ena = e; t.req = r; t.grant = g; t.sel = s; t.valid = v;
        vecs.push_back(t);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bus.ena = 1'b1;
        bus.req = 8'hFF;
        shuffle_in();

        // reset, then first grant from ptr=0
        #2 chk("reset_async", 8'h00, 3'd0, 1'b0);
        cycle();
        chk("reset_held", 8'h00, 3'd0, 1'b0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("first_grant", 8'h01, 3'd0, 1'b1);
        bus.req = 8'h00;
        cycle();
        chk("release_idle", 8'h00, 3'd0, 1'b0);

        // ptr=1: single requester 5 for 10 cycles, no gap at quantum end
        add(1, 8'h20, 8'h20, 3'd5, 1);
        for (int i = 0; i < 9; i++) add(1, 8'h20, 8'h20, 3'd5, 1);
        add(1, 8'h00, 8'h00, 3'd0, 0);
        // ptr=6: 7 and 0 alternate every 3 cycles, wrapping 7->0
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) add(1, 8'h81, 8'h80, 3'd7, 1);
            for (int i = 0; i < 3; i++) add(1, 8'h81, 8'h01, 3'd0, 1);
        end
        add(1, 8'h00, 8'h00, 3'd0, 0);
        // ptr=1: owner 2 releases after one cycle, 3 takes over at once
        add(1, 8'h0C, 8'h04, 3'd2, 1);
        add(1, 8'h08, 8'h08, 3'd3, 1);
        add(1, 8'h00, 8'h00, 3'd0, 0);
        // ptr=4: owner 0 keeps its quantum with ena low, then idles
        add(1, 8'h03, 8'h01, 3'd0, 1);
        add(0, 8'h03, 8'h01, 3'd0, 1);
        add(0, 8'h03, 8'h01, 3'd0, 1);
        add(0, 8'h03, 8'h00, 3'd0, 0);
        add(0, 8'h03, 8'h00, 3'd0, 0);
        add(1, 8'h03, 8'h02, 3'd1, 1);
        add(1, 8'h00, 8'h00, 3'd0, 0);

        foreach (vecs[k]) begin
            bus.ena = vecs[k].ena;
            bus.req = vecs[k].req;
            shuffle_in();
            cycle();
            chk($sformatf("vec%0d", k), vecs[k].grant, vecs[k].sel, vecs[k].valid);
        end

        // asynchronous reset between edges during a live grant
        bus.ena = 1'b1;
        bus.req = 8'h10;
        cycle();
        chk("pre_reset_grant", 8'h10, 3'd4, 1'b1);
        #3 rst_n = 1'b0;
        #1 chk("reset_mid_grant", 8'h00, 3'd0, 1'b0);
        cycle();
        chk("reset_mid_held", 8'h00, 3'd0, 1'b0);
        rst_n   = 1'b1;
        bus.req = 8'h04;
        cycle();
        chk("post_reset_grant", 8'h04, 3'd2, 1'b1);

        // ptr must restart at 0: with req 1 and 6 waiting, 1 wins
        #3 rst_n = 1'b0;
        #1 chk("reset_mid_grant2", 8'h00, 3'd0, 1'b0);
        cycle();
        rst_n   = 1'b1;
        bus.req = 8'h42;
        shuffle_in();
        cycle();
        chk("ptr_reset", 8'h02, 3'd1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
